// File: rtl/varredura_display.sv
// Time-multiplexed scanner for a 4-digit seven-segment display.
// Shadow registers are committed to the active set atomically at the frame wrap.
module varredura_display #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter logic [7:0]  BLANK_SEG    = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  input  logic [1:0] dig_sel,
  input  logic       wr_en,
  input  logic       commit,
  output logic [7:0] seg_out,
  output logic [3:0] an,
  output logic       pending,
  output logic       frame_done
);

  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned CNT_MAX    = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
  // Only meaningful when BLANK_CYCLES > 0; the BLANK state is unreachable otherwise.
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [1:0]       LAST_IDX   = 2'(NUM_DIGITS - 1);
  localparam logic [3:0]       AN_RESET   = 4'b1110;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [1:0]       idx, idx_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             pending_d;
  logic [7:0]       seg_d;
  logic [3:0]       an_d;
  logic             adv, wrap, xfer, wr_ok;
  logic [7:0]       shadow [MAX_DIGITS];
  logic [7:0]       active [MAX_DIGITS];

  // Next-state, dwell counter, commit bookkeeping and next output values.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt;
    adv       = 1'b0;
    wrap      = 1'b0;
    xfer      = 1'b0;
    pending_d = pending;
    seg_d     = BLANK_SEG;
    an_d      = 4'b1111;
    wr_ok     = wr_en && (32'(dig_sel) < NUM_DIGITS);

    unique case (state)
      ST_SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES > 0) state_d = ST_BLANK;
          else                  adv     = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHOW;
          adv     = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_SHOW;
        cnt_d   = '0;
      end
    endcase

    wrap = adv && (idx == LAST_IDX);
    if (adv) idx_d = wrap ? 2'd0 : idx + 2'd1;

    // The transfer uses the pending state from before the boundary edge.
    xfer = wrap && pending;
    if (wrap) pending_d = pending ? 1'b0 : commit;
    else      pending_d = pending | commit;

    // Digit 0 of a freshly committed frame must show the new data immediately.
    if (state_d == ST_SHOW) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = xfer ? shadow[idx_d] : active[idx_d];
    end
  end

  // State, scan position, register files and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SHOW;
      idx        <= 2'd0;
      cnt        <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      seg_out    <= BLANK_SEG;
      an         <= AN_RESET;
      for (int i = 0; i < MAX_DIGITS; i++) begin
        shadow[i] <= BLANK_SEG;
        active[i] <= BLANK_SEG;
      end
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      pending    <= pending_d;
      frame_done <= wrap;
      seg_out    <= seg_d;
      an         <= an_d;
      if (xfer) begin
        for (int i = 0; i < MAX_DIGITS; i++) active[i] <= shadow[i];
      end
      if (wr_ok) shadow[dig_sel] <= seg_in;
    end
  end

endmodule

// File: tb/tb_varredura_display.sv
// Directed bench for varredura_display: a 4-digit scanner with blanking and a
// 3-digit scanner without blanking, both with PRESCALE=4.
module tb_varredura_display;
  logic       clk, rst_n, wr_en, commit;
  logic [7:0] seg_in;
  logic [1:0] dig_sel;
  logic [7:0] seg_out, seg_out3;
  logic [3:0] an, an3;
  logic       pending, pending3, frame_done, frame_done3;
  int         total = 0;
  int         bad   = 0;
  int         n;
  logic [7:0] odd;

  varredura_display #(.NUM_DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .BLANK_SEG(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel), .wr_en(wr_en),
    .commit(commit), .seg_out(seg_out), .an(an), .pending(pending), .frame_done(frame_done)
  );

  varredura_display #(.NUM_DIGITS(3), .PRESCALE(4), .BLANK_CYCLES(0), .BLANK_SEG(8'hFF)) dut3 (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel), .wr_en(wr_en),
    .commit(commit), .seg_out(seg_out3), .an(an3), .pending(pending3), .frame_done(frame_done3)
  );

  typedef struct {
    logic       wr_en;
    logic [1:0] dig_sel;
    logic [7:0] seg_in;
    logic [7:0] seg;
    logic [3:0] an4;
    logic       fd4;
    logic [3:0] an3;
    logic       fd3;
  } vec_t;

  vec_t tbl [22];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until frame_done is seen (at least one cycle); n = cycles taken.
  task automatic wait_fd(input int budget, output int cnt);
    cnt = 0;
    do begin
      tick(1);
      cnt++;
    end while (frame_done !== 1'b1 && cnt < budget);
    chk("fd_reached", 8'(frame_done), 8'h01);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; commit = 1'b0; seg_in = 8'h00; dig_sel = 2'd0;

    // Cycle index = rising edges since reset release; writes must not reach seg_out.
    tbl[0]  = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1110, 1'b0, 4'b1110, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1110, 1'b0, 4'b1110, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 8'h5A, 8'hFF, 4'b1110, 1'b0, 4'b1110, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1110, 1'b0, 4'b1110, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1111, 1'b0, 4'b1101, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1101, 1'b0, 4'b1101, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1101, 1'b0, 4'b1101, 1'b0};
    tbl[7]  = '{1'b1, 2'd3, 8'h3C, 8'hFF, 4'b1101, 1'b0, 4'b1101, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1101, 1'b0, 4'b1011, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1111, 1'b0, 4'b1011, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1011, 1'b0, 4'b1011, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1011, 1'b0, 4'b1011, 1'b0};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1011, 1'b0, 4'b1110, 1'b1};
    tbl[13] = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1011, 1'b0, 4'b1110, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1111, 1'b0, 4'b1110, 1'b0};
    tbl[15] = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b0111, 1'b0, 4'b1110, 1'b0};
    tbl[16] = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b0111, 1'b0, 4'b1101, 1'b0};
    tbl[17] = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b0111, 1'b0, 4'b1101, 1'b0};
    tbl[18] = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b0111, 1'b0, 4'b1101, 1'b0};
    tbl[19] = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1111, 1'b0, 4'b1101, 1'b0};
    tbl[20] = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1110, 1'b1, 4'b1011, 1'b0};
    tbl[21] = '{1'b0, 2'd0, 8'h00, 8'hFF, 4'b1110, 1'b0, 4'b1011, 1'b0};

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_an", 8'(an), 8'h0E);
    chk("rst_seg", seg_out, 8'hFF);
    chk("rst_pend", 8'(pending), 8'h00);
    chk("rst_fd", 8'(frame_done), 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      wr_en = tbl[i].wr_en; dig_sel = tbl[i].dig_sel; seg_in = tbl[i].seg_in;
      chk($sformatf("tbl%0d_an4", i), 8'(an), 8'(tbl[i].an4));
      chk($sformatf("tbl%0d_fd4", i), 8'(frame_done), 8'(tbl[i].fd4));
      chk($sformatf("tbl%0d_seg4", i), seg_out, tbl[i].seg);
      chk($sformatf("tbl%0d_an3", i), 8'(an3), 8'(tbl[i].an3));
      chk($sformatf("tbl%0d_fd3", i), 8'(frame_done3), 8'(tbl[i].fd3));
      chk($sformatf("tbl%0d_seg3", i), seg_out3, tbl[i].seg);
      tick(1);
    end
    wr_en = 1'b0;

    // Frame period: next pulse at cycle 40, then 20 cycles to cycle 60.
    wait_fd(40, n);
    chk("gap_to_fd", 8'(n), 8'd18);
    wait_fd(40, n);
    chk("frame_len", 8'(n), 8'd20);

    // Cycle 60: load shadow 0..3 without commit.
    for (int d = 0; d < 4; d++) begin
      wr_en = 1'b1; dig_sel = 2'(d);
      case (d)
        0: seg_in = 8'hC0;
        1: seg_in = 8'hF9;
        2: seg_in = 8'hA4;
        default: seg_in = 8'hB0;
      endcase
      tick(1);
    end
    wr_en = 1'b0;
    odd = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      if (seg_out !== 8'hFF) odd = seg_out;
      tick(1);
    end
    chk("nocommit_seg", odd, 8'hFF);
    chk("nocommit_pend", 8'(pending), 8'h00);

    // Cycle 84: commit; transfer at the wrap into cycle 100.
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    chk("commit_pend", 8'(pending), 8'h01);
    wait_fd(40, n);
    chk("commit_wait", 8'(n), 8'd15);
    chk("wrap_an", 8'(an), 8'h0E);
    chk("wrap_seg0", seg_out, 8'hC0);
    chk("wrap_pend", 8'(pending), 8'h00);
    tick(4);
    chk("blank_an", 8'(an), 8'h0F);
    chk("blank_seg", seg_out, 8'hFF);
    tick(1);
    chk("d1_an", 8'(an), 8'h0D);
    chk("d1_seg", seg_out, 8'hF9);
    tick(5);
    chk("d2_an", 8'(an), 8'h0B);
    chk("d2_seg", seg_out, 8'hA4);
    tick(5);
    chk("d3_an", 8'(an), 8'h07);
    chk("d3_seg", seg_out, 8'hB0);
    tick(5);

    // Cycle 120: new shadow 0 value, then commit exactly on the boundary cycle.
    wr_en = 1'b1; dig_sel = 2'd0; seg_in = 8'h88;
    tick(1);
    wr_en = 1'b0;
    chk("wr_no_effect", seg_out, 8'hC0);
    tick(18);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    chk("bnd_fd", 8'(frame_done), 8'h01);
    chk("bnd_seg_old", seg_out, 8'hC0);
    chk("bnd_pend", 8'(pending), 8'h01);
    tick(10);
    chk("bnd_mid_pend", 8'(pending), 8'h01);
    tick(10);
    chk("bnd2_fd", 8'(frame_done), 8'h01);
    chk("bnd2_seg_new", seg_out, 8'h88);
    chk("bnd2_pend", 8'(pending), 8'h00);

    // Cycle 161: write plus commit together; commit again on the boundary with pending set.
    tick(1);
    wr_en = 1'b1; dig_sel = 2'd1; seg_in = 8'h99; commit = 1'b1;
    tick(1);
    wr_en = 1'b0; commit = 1'b0;
    chk("wrc_pend", 8'(pending), 8'h01);
    tick(17);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    chk("wrc_fd", 8'(frame_done), 8'h01);
    chk("wrc_pend_clr", 8'(pending), 8'h00);
    chk("wrc_seg0", seg_out, 8'h88);
    tick(5);
    chk("wrc_an1", 8'(an), 8'h0D);
    chk("wrc_seg1", seg_out, 8'h99);

    // Cycle 190: commit, then asynchronous reset during the digit-2 dwell.
    tick(5);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    chk("pre_rst_an", 8'(an), 8'h0B);
    chk("pre_rst_seg", seg_out, 8'hA4);
    chk("pre_rst_pend", 8'(pending), 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", 8'(an), 8'h0E);
    chk("arst_seg", seg_out, 8'hFF);
    chk("arst_pend", 8'(pending), 8'h00);
    chk("arst_fd", 8'(frame_done), 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rel_an", 8'(an), 8'h0E);
    tick(5);
    chk("rel_an1", 8'(an), 8'h0D);
    chk("rel_seg1", seg_out, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/varredura_display.md
Name: varredura_display

Overview:
- Time-multiplexed scanner for a 4-digit seven-segment display, directly downstream of the BCD-to-segment encoder.
- Accepts 8-bit segment patterns (7 segments plus decimal point) through a write port into shadow registers.
- Commits them atomically at a frame boundary, then cycles the digit anodes with a programmable dwell time and an inter-digit blanking gap to suppress ghosting.

Parameters:
- NUM_DIGITS, 4: number of digits scanned, legal range 1..4.
- PRESCALE, 1000: clock cycles each digit is lit (SHOW dwell), must be ≥1.
- BLANK_CYCLES, 2: clock cycles all anodes are off between digits; 0 disables the BLANK state.
- BLANK_SEG, 8'hFF: segment value driven while blanked and the reset contents of all digit registers.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- seg_in  in  8  segment pattern from the encoder (its y output), passed verbatim (no polarity change).
- dig_sel  in  2  shadow register index for a write.
- wr_en  in  1  write strobe: shadow[dig_sel] <= seg_in on this edge.
- commit  in  1  request to copy all shadow registers to active registers at the next frame boundary.
- seg_out  out  8  segment lines of the currently lit digit.
- an  out  4  anode enables, active-low one-hot; bits ≥ NUM_DIGITS always 1.
- pending  out  1  a commit is requested but not yet applied.
- frame_done  out  1  one-cycle pulse on the cycle the scan wraps to digit 0.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values (asynchronous): shadow[*] = active[*] = BLANK_SEG, state = SHOW, idx = 0, cnt = 0, pending = 0, frame_done = 0.
- Outputs are driven only from registers, never combinationally from inputs.
- State SHOW:
  - an = ~(1<<idx) over NUM_DIGITS bits; seg_out = active[idx].
  - cnt counts 0..PRESCALE-1.
  - At cnt == PRESCALE-1: if BLANK_CYCLES > 0, go to BLANK with cnt = 0; otherwise advance idx directly, stay in SHOW, cnt = 0.
- State BLANK:
  - an = 4'b1111; seg_out = BLANK_SEG.
  - cnt counts 0..BLANK_CYCLES-1, then advance idx and go to SHOW with cnt = 0.
- Advance: idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
- Frame boundary (the wrap from NUM_DIGITS-1 to 0):
  - frame_done = 1 for exactly the first cycle with idx = 0.
  - If pending was 1 before that edge, active[*] <= shadow[*] on that edge and pending <= 0.
- Frame length and commit timing:
  - Frame length = NUM_DIGITS*(PRESCALE+BLANK_CYCLES) cycles.
  - Digit 0 of the new frame shows committed data from its first lit cycle.
- Writes:
  - wr_en with dig_sel ≥ NUM_DIGITS is ignored.
  - Writes never alter active[*] or seg_out directly.
- commit:
  - commit = 1 sets pending on the next edge.
  - Repeated commits while pending are idempotent.
- Simultaneous events:
  - wr_en and commit in the same cycle: the write lands in shadow and is included in that commit.
  - commit asserted on the boundary edge itself: the transfer on that edge uses the old pending state. If pending was 0, the new request stays pending until the following frame. If pending was already 1, the transfer happens and pending ends at 0 (the transfer wins).
  - A write on the boundary edge: the transfer samples shadow before the write; the new value waits for the next commit.
- NUM_DIGITS = 1: idx stays 0; every SHOW→(BLANK→)SHOW cycle is a frame boundary and frame_done pulses each dwell.
- Reset mid-scan: all state returns to reset values immediately (anode output goes to 4'b1110 since SHOW idx 0 is lit). Shadow contents and pending requests are lost.

Test Plan (PRESCALE=4, BLANK_CYCLES=1, NUM_DIGITS=4 unless noted):
- Release reset, no writes.
  - Required: an = 1110, 1111, 1101, 1111, 1011, 1111, 0111, 1111 repeating.
  - Required: each an value held 4 cycles, each blank held 1 cycle, seg_out always 8'hFF.
  - Required: frame_done pulses every 20 cycles.
- Write shadow 0..3 = 8'hC0, 8'hF9, 8'hA4, 8'hB0 without commit.
  - Required: seg_out stays 8'hFF for a whole frame.
  - Then pulse commit: pending = 1 until the wrap; from the first frame_done cycle, digit 0 shows 8'hC0, digit 1 8'hF9, etc.
  - Required: pending = 0 after the wrap.
- Pulse commit on the exact boundary cycle with pending = 0.
  - Required: no transfer on that wrap, pending = 1 for one full frame, transfer on the next wrap.
- wr_en with dig_sel = 1, seg_in = 8'h99, in the same cycle as commit.
  - Required: after the next wrap, digit 1 shows 8'h99.
- Assert rst_n = 0 during the digit-2 dwell.
  - Required: an = 1110, seg_out = 8'hFF, pending = 0 immediately, without waiting for a clock edge.
  - Required: the scan restarts from digit 0 after release.
- Run with BLANK_CYCLES=0, NUM_DIGITS=3.
  - Required: an = 110, 101, 011 cycle with no 111 gaps, bit 3 always 1, frame length 12 cycles.
